// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops and compares, iterative shifts,
// with a registered valid/ready output slot.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_branch
);

  localparam int unsigned SW   = $clog2(DATA_WIDTH);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_XOR = 4'b0010, OP_OR  = 4'b0011,
    OP_AND = 4'b0100, OP_SLT = 4'b0101, OP_SRA = 4'b0110, OP_SRL = 4'b0111,
    OP_SLL = 4'b1000, OP_NE  = 4'b1010, OP_LT  = 4'b1011, OP_GE  = 4'b1100,
    OP_EQ  = 4'b1101
  } op_e;

  typedef enum logic [1:0] {K_SRA, K_SRL, K_SLL} shift_kind_e;
  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e                r_state;
  shift_kind_e           r_kind;
  logic [DATA_WIDTH-1:0] r_work;
  logic [SW-1:0]         r_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_result;
  logic                  r_out_branch;

  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_branch;
  logic                  w_is_shift;
  logic [SW-1:0]         w_shamt;
  logic                  w_accept;
  logic                  w_start_shift;
  logic [SW:0]           w_count_ext;
  logic [SW:0]           w_k;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_work_next;
  shift_kind_e           w_kind;

  assign w_shamt       = SrcB[SW-1:0];
  assign in_ready      = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_start_shift = w_is_shift && (w_shamt != '0);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu_result = '0;
    w_alu_branch = 1'b0;
    w_is_shift   = 1'b0;
    w_kind       = K_SRL;
    case (op_e'(Operation))
      OP_ADD: w_alu_result = SrcA + SrcB;
      OP_SUB: w_alu_result = SrcA - SrcB;
      OP_XOR: w_alu_result = SrcA ^ SrcB;
      OP_OR:  w_alu_result = SrcA | SrcB;
      OP_AND: w_alu_result = SrcA & SrcB;
      OP_SLT: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      // Zero-amount shifts pass SrcA straight through in one cycle.
      OP_SRA: begin w_is_shift = 1'b1; w_kind = K_SRA; w_alu_result = SrcA; end
      OP_SRL: begin w_is_shift = 1'b1; w_kind = K_SRL; w_alu_result = SrcA; end
      OP_SLL: begin w_is_shift = 1'b1; w_kind = K_SLL; w_alu_result = SrcA; end
      OP_NE:  w_alu_branch = (SrcA != SrcB);
      OP_LT:  w_alu_branch = ($signed(SrcA) <  $signed(SrcB));
      OP_GE:  w_alu_branch = ($signed(SrcA) >= $signed(SrcB));
      OP_EQ:  w_alu_branch = (SrcA == SrcB);
      default: ;
    endcase
    if (w_alu_branch) w_alu_result = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  end

  assign w_count_ext = {1'b0, r_count};
  assign w_k         = (w_count_ext > STEP) ? STEP : w_count_ext;
  assign w_last      = (w_k == w_count_ext);

  // Arithmetic shift keeps replicating the MSB, which is still the original sign bit.
  always_comb begin
    case (r_kind)
      K_SRA:   w_work_next = $signed(r_work) >>> w_k;
      K_SLL:   w_work_next = r_work << w_k;
      default: w_work_next = r_work >> w_k;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_kind       <= K_SRL;
      r_work       <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_branch <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
        r_out_result <= '0;
        r_out_branch <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_state <= S_SHIFT;
              r_work  <= SrcA;
              r_count <= w_shamt;
              r_kind  <= w_kind;
            end else begin
              r_out_valid  <= 1'b1;
              r_out_result <= w_alu_result;
              r_out_branch <= w_alu_branch;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_work_next;
          r_count <= r_count - w_k[SW-1:0];
          if (w_last) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b1;
            r_out_result <= w_work_next;
            r_out_branch <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_branch = r_out_branch;

endmodule
